// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA sprite engine: default visible area,
//   motion-mode encodings, the frame-update FSM state set and the
//   per-axis direction encoding.
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;
  localparam int POS_W        = 10;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_WRAP   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_UPD_X = 2'd2,
    ST_UPD_Y = 2'd3
  } state_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

endpackage

// File: rtl/sprite_axis_mover.sv
// ---------------------------------------------------------------------------
// sprite_axis_mover
//   Holds the sprite position and travel direction for one axis and applies
//   one motion step per update strobe.
// Ports:
//   clk_50MHz, rst : system clock, asynchronous active-high reset
//   upd            : one-clk update strobe
//   mode           : motion mode latched for this frame
//   step           : distance to move on this update
//   max_pos        : largest legal position on this axis
//   pos            : current position
//   wrap           : set when the last update wrapped back to 0 (wrap mode)
// ---------------------------------------------------------------------------
module sprite_axis_mover
  import vga_pkg::*;
(
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             upd,
  input  mode_e            mode,
  input  logic [POS_W-1:0] step,
  input  logic [POS_W-1:0] max_pos,
  output logic [POS_W-1:0] pos,
  output logic             wrap
);

  logic [POS_W-1:0] pos_q, pos_d;
  dir_e             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic [POS_W:0]   sum;

  // One extra bit so pos+step cannot overflow before the limit compare.
  assign sum = {1'b0, pos_q} + {1'b0, step};

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    wrap_d = wrap_q;
    if (upd) begin
      wrap_d = 1'b0;
      case (mode)
        MODE_WRAP: begin
          if (sum > {1'b0, max_pos}) begin
            pos_d  = '0;
            wrap_d = 1'b1;
          end else begin
            pos_d = sum[POS_W-1:0];
          end
        end
        MODE_BOUNCE: begin
          // A zero step holds position and never flips direction.
          if (step != '0) begin
            if (dir_q == DIR_POS) begin
              if (sum >= {1'b0, max_pos}) begin
                pos_d = max_pos;
                dir_d = DIR_NEG;
              end else begin
                pos_d = sum[POS_W-1:0];
              end
            end else begin
              // pos < step or pos-step == 0, i.e. the step reaches 0.
              if (pos_q <= step) begin
                pos_d = '0;
                dir_d = DIR_POS;
              end else begin
                pos_d = pos_q - step;
              end
            end
          end
        end
        default: ; // static and reserved modes hold position
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      pos_q  <= '0;
      dir_q  <= DIR_POS;
      wrap_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
    end
  end

  assign pos  = pos_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/vga_sprite_engine.sv
// ---------------------------------------------------------------------------
// vga_sprite_engine
//   Overlays a ROM-held sprite on a solid background and moves the sprite
//   once per frame (static, raster-wrap or bounce). Everything runs in the
//   clk_50MHz domain; vsync is only edge-detected.
// Ports:
//   clk_50MHz, rst     : system clock, asynchronous active-high reset
//   p_tick             : one-clk pixel enable
//   vsync, video_on    : sync level and active-video flag from vga_sync
//   pixel_x, pixel_y   : current pixel coordinates
//   enable, mode, speed: motion controls, sampled on frame_start
//   rom_addr, rom_data : sprite ROM interface (data valid one p_tick later)
//   rgb                : pixel colour, 2 p_ticks after the pixel coordinates
//   pos_x, pos_y       : sprite top-left corner
//   frame_start        : one-clk pulse on vsync rising edge
// ---------------------------------------------------------------------------
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int                 H_ACTIVE    = VGA_H_ACTIVE,
  parameter int                 V_ACTIVE    = VGA_V_ACTIVE,
  parameter int                 SPR_W       = 200,
  parameter int                 SPR_H       = 100,
  parameter int                 COLOR_W     = 6,
  parameter int                 ADDR_W      = 16,
  parameter logic [COLOR_W-1:0] BG_COLOR    = '1,
  parameter logic [COLOR_W-1:0] KEY_COLOR   = '0,
  parameter int                 WRAP_STEP_Y = 50
) (
  input  logic               clk_50MHz,
  input  logic               rst,
  input  logic               p_tick,
  input  logic               vsync,
  input  logic               video_on,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [3:0]         speed,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0] rgb,
  output logic [9:0]         pos_x,
  output logic [9:0]         pos_y,
  output logic               frame_start
);

  localparam logic [POS_W-1:0] XMAX = POS_W'(H_ACTIVE - SPR_W);
  localparam logic [POS_W-1:0] YMAX = POS_W'(V_ACTIVE - SPR_H);

  // ---------------- frame detect and motion control ----------------
  logic       vsync_q;
  state_e     state_q, state_d;
  mode_e      mode_q, mode_d;
  logic [3:0] speed_q, speed_d;
  logic       wrap_x, wrap_y;
  logic       upd_x, upd_y;
  logic [POS_W-1:0] step_y;

  assign frame_start = vsync & ~vsync_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    speed_d = speed_q;
    // Motion controls are frozen for the whole frame at its start.
    if (frame_start) begin
      mode_d  = mode_e'(mode);
      speed_d = speed;
    end
    case (state_q)
      ST_IDLE:  if (frame_start)           state_d = ST_WAIT;
      ST_WAIT:  if (frame_start && enable) state_d = ST_UPD_X;
      ST_UPD_X:                            state_d = ST_UPD_Y;
      ST_UPD_Y:                            state_d = ST_WAIT;
      default:                             state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      state_q <= ST_IDLE;
      mode_q  <= MODE_STATIC;
      speed_q <= '0;
    end else begin
      vsync_q <= vsync;
      state_q <= state_d;
      mode_q  <= mode_d;
      speed_q <= speed_d;
    end
  end

  // In wrap mode y only steps when x has just wrapped to the next row band.
  assign upd_x  = (state_q == ST_UPD_X);
  assign upd_y  = (state_q == ST_UPD_Y) && ((mode_q != MODE_WRAP) || wrap_x);
  assign step_y = (mode_q == MODE_WRAP) ? POS_W'(WRAP_STEP_Y) : POS_W'(speed_q);

  sprite_axis_mover u_mover_x (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .upd       (upd_x),
    .mode      (mode_q),
    .step      (POS_W'(speed_q)),
    .max_pos   (XMAX),
    .pos       (pos_x),
    .wrap      (wrap_x)
  );

  sprite_axis_mover u_mover_y (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .upd       (upd_y),
    .mode      (mode_q),
    .step      (step_y),
    .max_pos   (YMAX),
    .pos       (pos_y),
    .wrap      (wrap_y)
  );

  // ---------------- window compare and pixel pipeline ----------------
  logic [POS_W:0]     x_end, y_end;
  logic [POS_W-1:0]   dx, dy;
  logic               in_win;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               in_win_q, in_win_d;
  logic               video_on_q, video_on_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;

  assign x_end  = {1'b0, pos_x} + (POS_W+1)'(SPR_W - 1);
  assign y_end  = {1'b0, pos_y} + (POS_W+1)'(SPR_H - 1);
  assign in_win = (pixel_x >= pos_x) && ({1'b0, pixel_x} <= x_end) &&
                  (pixel_y >= pos_y) && ({1'b0, pixel_y} <= y_end);
  assign dx     = pixel_x - pos_x;
  assign dy     = pixel_y - pos_y;

  always_comb begin
    rom_addr_d = rom_addr_q;
    in_win_d   = in_win_q;
    video_on_d = video_on_q;
    rgb_d      = rgb_q;
    if (p_tick) begin
      // Stage 1: address is only recomputed inside the sprite window.
      if (in_win) begin
        rom_addr_d = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
      end
      in_win_d   = in_win;
      video_on_d = video_on;
      // Stage 2: rom_data now belongs to the address registered last tick.
      if (!video_on_q) begin
        rgb_d = '0;
      end else if (in_win_q && (rom_data != KEY_COLOR)) begin
        rgb_d = rom_data;
      end else begin
        rgb_d = BG_COLOR;
      end
    end
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      rom_addr_q <= '0;
      in_win_q   <= 1'b0;
      video_on_q <= 1'b0;
      rgb_q      <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      in_win_q   <= in_win_d;
      video_on_q <= video_on_d;
      rgb_q      <= rgb_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rgb      = rgb_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// ---------------------------------------------------------------------------
// tb_vga_sprite_engine
//   Directed bench with a scoreboard: each pixel beat pushes its expected rgb;
//   a monitor pops on every p_tick and compares one beat late (2-tick latency).
// ---------------------------------------------------------------------------
module tb_vga_sprite_engine;

  logic        clk_50MHz = 1'b0;
  logic        rst;
  logic        p_tick;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic        enable;
  logic [1:0]  mode;
  logic [3:0]  speed;
  logic [15:0] rom_addr;
  logic [5:0]  rom_data;
  logic [5:0]  rgb;
  logic [9:0]  pos_x, pos_y;
  logic        frame_start;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0] rgb;
    bit         chk;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  always #10 clk_50MHz = ~clk_50MHz;

  vga_sprite_engine dut (
    .clk_50MHz   (clk_50MHz),
    .rst         (rst),
    .p_tick      (p_tick),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .enable      (enable),
    .mode        (mode),
    .speed       (speed),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rgb         (rgb),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .frame_start (frame_start)
  );

  // Sprite ROM model: addr 0 -> 6'h15, last pixel -> key colour, else a
  // pattern derived from the low address bits.
  function automatic logic [5:0] rom_fn(input logic [15:0] a);
    if (a == 16'd0)     return 6'h15;
    if (a == 16'd19999) return 6'h00;
    return {a[4:0], 1'b1};
  endfunction

  always_comb rom_data = rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: on each p_tick edge rgb holds the result of the previous beat.
  initial begin : monitor
    exp_t prev;
    bit   have_prev;
    have_prev = 1'b0;
    forever begin
      @(posedge clk_50MHz);
      #1;
      if (rst) begin
        have_prev = 1'b0;
        exp_q.delete();
      end else if (p_tick) begin
        if (have_prev && prev.chk) check(prev.tag, 32'(rgb), 32'(prev.rgb));
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard_empty: got 0 entries, expected 1");
          have_prev = 1'b0;
        end else begin
          prev      = exp_q.pop_front();
          have_prev = 1'b1;
        end
      end
    end
  end

  task automatic send_pixel(input int x, input int y, input bit von,
                            input logic [5:0] exp, input bit chk, input string tag);
    exp_t e;
    e.rgb = exp;
    e.chk = chk;
    e.tag = tag;
    @(negedge clk_50MHz);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    exp_q.push_back(e);
    p_tick = 1'b1;
    @(negedge clk_50MHz);
    p_tick = 1'b0;
    @(negedge clk_50MHz);
  endtask

  // Unchecked beat that pushes the last real beat through stage 2.
  task automatic flush();
    send_pixel(0, 0, 1'b0, 6'h00, 1'b0, "flush");
  endtask

  task automatic do_frame(input bit chg, input logic [1:0] new_mode);
    @(negedge clk_50MHz);
    vsync = 1'b1;
    #1 check("frame_start_rise", 32'(frame_start), 32'd1);
    @(posedge clk_50MHz);
    #1 check("frame_start_width", 32'(frame_start), 32'd0);
    if (chg) mode = new_mode;
    repeat (4) @(negedge clk_50MHz);
    vsync = 1'b0;
    repeat (2) @(negedge clk_50MHz);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) do_frame(1'b0, 2'd0);
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, "_pos_x"}, 32'(pos_x), 32'(ex));
    check({tag, "_pos_y"}, 32'(pos_y), 32'(ey));
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  initial begin : watchdog
    #2_000_000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    summary();
    $finish;
  end

  initial begin : stimulus
    rst = 1'b1; p_tick = 1'b0; vsync = 1'b0; video_on = 1'b0;
    pixel_x = '0; pixel_y = '0; enable = 1'b0; mode = 2'd0; speed = 4'd0;
    repeat (3) @(negedge clk_50MHz);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_pos("rst", 0, 0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    rst = 1'b0;

    // Static mode: nothing moves; basic pixel path.
    mode = 2'd0; speed = 4'd5; enable = 1'b1;
    frames(3);
    check_pos("static", 0, 0);
    send_pixel(0, 0, 1'b1, 6'h15, 1'b1, "px_0_0");
    send_pixel(200, 0, 1'b1, 6'h3F, 1'b1, "px_200_0_bg");
    send_pixel(5, 5, 1'b0, 6'h00, 1'b1, "px_blank");
    flush();

    // Wrap mode, speed 10.
    mode = 2'd1; speed = 4'd10;
    frames(44);
    check_pos("wrap_xmax", 440, 0);
    frames(1);
    check_pos("wrap_first", 0, 50);
    frames(6 * 45);
    check_pos("wrap_y350", 0, 350);
    frames(44);
    check_pos("wrap_x440_y350", 440, 350);
    frames(1);
    check_pos("wrap_y_to_0", 0, 0);

    // Bounce mode, speed 7 (y bounces off 380 along the way).
    mode = 2'd2; speed = 4'd7;
    frames(62);
    check_pos("bounce_434", 434, 331);
    frames(1);
    check_pos("bounce_hit_max", 440, 324);
    frames(1);
    check_pos("bounce_back", 433, 317);
    speed = 4'd10;
    frames(43);
    check_pos("bounce_x3", 3, 110);
    speed = 4'd7;
    frames(1);
    check_pos("bounce_hit_0", 0, 117);
    frames(1);
    check_pos("bounce_dir_pos", 7, 124);

    // Freeze, zero speed, then mid-frame mode change.
    enable = 1'b0;
    frames(2);
    check_pos("freeze", 7, 124);
    enable = 1'b1; speed = 4'd0;
    frames(1);
    check_pos("speed0", 7, 124);
    speed = 4'd7;
    frames(1);
    check_pos("after_speed0", 14, 131);
    do_frame(1'b1, 2'd0);
    check_pos("midframe_mode", 21, 138);
    frames(1);
    check_pos("static_again", 21, 138);

    // Window edges, key colour and address at the last sprite pixel.
    send_pixel(21, 138, 1'b1, 6'h15, 1'b1, "win_origin");
    send_pixel(30, 140, 1'b1, 6'h33, 1'b1, "win_addr409");
    send_pixel(20, 138, 1'b1, 6'h3F, 1'b1, "win_left_out");
    send_pixel(21, 137, 1'b1, 6'h3F, 1'b1, "win_top_out");
    send_pixel(220, 237, 1'b1, 6'h3F, 1'b1, "win_last_key");
    check("rom_addr_last", 32'(rom_addr), 32'd19999);
    send_pixel(221, 237, 1'b1, 6'h3F, 1'b1, "win_right_out");
    check("rom_addr_hold", 32'(rom_addr), 32'd19999);
    send_pixel(21, 238, 1'b1, 6'h3F, 1'b1, "win_bottom_out");
    send_pixel(220, 237, 1'b0, 6'h00, 1'b1, "win_blank");
    send_pixel(21, 138, 1'b1, 6'h15, 1'b1, "pre_reset_px");
    flush();

    // Asynchronous reset mid-line.
    @(negedge clk_50MHz);
    #3 rst = 1'b1;
    #1;
    check("arst_rgb", 32'(rgb), 32'd0);
    check("arst_rom_addr", 32'(rom_addr), 32'd0);
    check_pos("arst", 0, 0);
    repeat (2) @(negedge clk_50MHz);
    rst = 1'b0;
    check("post_rst_rgb", 32'(rgb), 32'd0);
    mode = 2'd1; speed = 4'd10; enable = 1'b1;
    frames(1);
    check_pos("post_rst_frame1", 0, 0);
    frames(1);
    check_pos("post_rst_frame2", 10, 0);

    repeat (4) @(negedge clk_50MHz);
    summary();
    $finish;
  end

endmodule
